// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_controller_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } hz_state_t;

    // Pipeline register control bundle, one bit per top-level control output.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic idex_bubble;
        logic flush_ifid;
        logic flush_idex;
        logic memwb_bubble;
    } pipe_ctrl_t;

    // Everything off: used while reset is held.
    localparam pipe_ctrl_t CTRL_IDLE     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Whole pipe held, NOP drains into MEM/WB.
    localparam pipe_ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // Taken branch: advance and squash the two younger stages.
    localparam pipe_ctrl_t CTRL_FLUSH    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    // Plain advance.
    localparam pipe_ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating event counter with synchronous active-low clear.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // Count enabled events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, branch flushes,
// data-memory freeze with timeout watchdog, and stall/flush counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  memread_IDEX,
    input  logic                  regwrite_IDEX,
    input  logic [REG_ADDR_W-1:0] rd_IDEX,
    input  logic [REG_ADDR_W-1:0] rs1_ID,
    input  logic [REG_ADDR_W-1:0] rs2_ID,
    input  logic                  use_rs1_ID,
    input  logic                  use_rs2_ID,
    input  logic                  branch_taken_EXMEM,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_write,
    output logic                  exmem_write,
    output logic                  idex_bubble,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic                  memwb_bubble,
    output logic                  mem_error,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // Wide enough to hold MEM_TIMEOUT itself.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t   state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    pipe_ctrl_t  ctrl;
    logic        mem_stall;
    logic        freeze;
    logic        load_use;
    logic [1:0]  cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    // Hazard detection: memory stall and load-use register match.
    always_comb begin
        mem_stall = dmem_req && !dmem_ready;
        freeze    = (state_reg == MEM_ERR) || mem_stall;
        load_use  = memread_IDEX && regwrite_IDEX && (rd_IDEX != '0) &&
                    ((use_rs1_ID && (rs1_ID == rd_IDEX)) ||
                     (use_rs2_ID && (rs2_ID == rd_IDEX)));
    end

    // Priority decode of pipe controls plus counter increment requests.
    always_comb begin
        ctrl    = CTRL_IDLE;
        cnt_inc = 2'b00;
        if (!arst_n) begin
            ctrl = CTRL_IDLE;
        end else if (freeze) begin
            ctrl       = CTRL_FREEZE;
            cnt_inc[0] = 1'b1;
        end else if (branch_taken_EXMEM) begin
            // The branch wins over load-use: the stalled instruction is squashed anyway.
            ctrl       = CTRL_FLUSH;
            cnt_inc[1] = 1'b1;
        end else if (load_use) begin
            ctrl       = CTRL_LOAD_USE;
            cnt_inc[0] = 1'b1;
        end else begin
            ctrl = CTRL_NORMAL;
        end
    end

    // Next-state logic for the memory-wait sequencer and its wait counter.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            RUN: begin
                if (mem_stall) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    // This is freeze cycle MEM_TIMEOUT: give up on memory.
                    state_next    = MEM_ERR;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            MEM_ERR: begin
                state_next = MEM_ERR;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Index 0 counts stalls (freeze or load-use), index 1 counts flushes.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .clr_n (arst_n),
            .inc   (cnt_inc[gi]),
            .count (cnt_val[gi])
        );
    end

    assign stall_cnt    = cnt_val[0];
    assign flush_cnt    = cnt_val[1];
    assign pc_write     = ctrl.pc_write;
    assign ifid_write   = ctrl.ifid_write;
    assign idex_write   = ctrl.idex_write;
    assign exmem_write  = ctrl.exmem_write;
    assign idex_bubble  = ctrl.idex_bubble;
    assign flush_ifid   = ctrl.flush_ifid;
    assign flush_idex   = ctrl.flush_idex;
    assign memwb_bubble = ctrl.memwb_bubble;
    assign mem_error    = (state_reg == MEM_ERR);

endmodule
